fetch_unit_pf: RTL

- Parametrised instruction-fetch stage with a decoupled prefetch buffer.
- Sits between the word-addressed synchronous instruction RAM (1-cycle read latency) and decode.
- Generalises the fixed 4-bit fetch stage to a configurable address/data width, a configurable reset vector and a small prefetch FIFO.
- Adds a valid/ready handshake toward decode (decode stalls are absorbed) and redirect with flush/kill of in-flight reads.

---
 rtl/fetch_unit_pf_pkg.sv | 14 +
 rtl/fetch_unit_pf_if.sv | 28 ++
 rtl/fetch_unit_pf_fifo.sv | 59 +++++
 rtl/fetch_unit_pf.sv | 112 +++++++++++
 4 files changed

// File: rtl/fetch_unit_pf_pkg.sv
// Shared constants and types for the prefetching instruction-fetch stage.
package fetch_unit_pf_pkg;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_DEPTH    = 2;
    localparam int DEF_RESET_PC = 0;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] instr;
        logic [DEF_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_pf_if.sv
// Bundle of instruction-RAM, redirect and decode-side signals of the fetch stage.
interface fetch_unit_pf_if
    import fetch_unit_pf_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic [ADDR_W-1:0] out_pc_next;

    modport master (
        input  redirect_valid, redirect_addr, imem_rdata, out_ready,
        output imem_en, imem_addr, out_valid, out_instr, out_pc, out_pc_next
    );

    modport slave (
        output redirect_valid, redirect_addr, imem_rdata, out_ready,
        input  imem_en, imem_addr, out_valid, out_instr, out_pc, out_pc_next
    );
endinterface

// File: rtl/fetch_unit_pf_fifo.sv
// Small synchronous FIFO with flush; head word is presented combinationally.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 40
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    // Storage, pointers and occupancy; flush wins over push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/fetch_unit_pf.sv
// Instruction-fetch stage: PC, credit-limited RAM issue, kill on redirect, prefetch FIFO.
module fetch_unit_pf
    import fetch_unit_pf_pkg::*;
#(
    parameter int              ADDR_W   = DEF_ADDR_W,
    parameter int              DATA_W   = DEF_DATA_W,
    parameter int              DEPTH    = DEF_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic           clk,
    input  logic           reset,
    fetch_unit_pf_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = DATA_W + ADDR_W;

    logic [ADDR_W-1:0] pc_r;
    logic              inflight_r;
    logic [ADDR_W-1:0] inflight_addr_r;

    logic [ADDR_W-1:0] fetch_addr_s;
    logic              issue_s;
    logic              push_s;
    logic              pop_s;
    logic              nonempty_s;
    logic [CW-1:0]     count_s;
    logic [CW:0]       pending_s;
    logic [EW-1:0]     wdata_s;
    logic [EW-1:0]     head_s;
    logic [DATA_W-1:0] out_instr_s;
    logic [ADDR_W-1:0] out_pc_s;
    logic [ADDR_W-1:0] out_pc_next_s;

    // Issue decision: a redirect always issues; otherwise only when a FIFO slot is guaranteed.
    always_comb begin
        fetch_addr_s = pc_r;
        issue_s      = 1'b0;
        nonempty_s   = (count_s != '0);
        pop_s        = nonempty_s && !bus.redirect_valid && bus.out_ready;
        push_s       = inflight_r && !bus.redirect_valid;
        pending_s    = {1'b0, count_s} + {{CW{1'b0}}, inflight_r} - {{CW{1'b0}}, pop_s};
        wdata_s      = {bus.imem_rdata, inflight_addr_r};
        if (bus.redirect_valid) begin
            fetch_addr_s = bus.redirect_addr;
        end else begin
            fetch_addr_s = pc_r;
        end
        if (reset) begin
            issue_s = 1'b0;
        end else if (bus.redirect_valid) begin
            issue_s = 1'b1;
        end else begin
            issue_s = (int'(pending_s) < DEPTH);
        end
    end

    // PC advance and in-flight read tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r            <= RESET_PC;
            inflight_r      <= 1'b0;
            inflight_addr_r <= '0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                pc_r            <= fetch_addr_s + ADDR_W'(1);
                inflight_addr_r <= fetch_addr_s;
            end else begin
                pc_r            <= pc_r;
                inflight_addr_r <= inflight_addr_r;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .flush (bus.redirect_valid),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (wdata_s),
        .rdata (head_s),
        .count (count_s)
    );

    // Head fields are zeroed while empty so idle outputs read as all-zero.
    always_comb begin
        out_instr_s   = '0;
        out_pc_s      = '0;
        out_pc_next_s = '0;
        if (nonempty_s) begin
            out_instr_s   = head_s[EW-1:ADDR_W];
            out_pc_s      = head_s[ADDR_W-1:0];
            out_pc_next_s = head_s[ADDR_W-1:0] + ADDR_W'(1);
        end else begin
            out_instr_s   = '0;
            out_pc_s      = '0;
            out_pc_next_s = '0;
        end
    end

    assign bus.imem_en     = issue_s;
    assign bus.imem_addr   = fetch_addr_s;
    assign bus.out_valid   = nonempty_s && !bus.redirect_valid;
    assign bus.out_instr   = out_instr_s;
    assign bus.out_pc      = out_pc_s;
    assign bus.out_pc_next = out_pc_next_s;

endmodule
